mem_port_arbiter: RTL

- Shares the single data-memory port between the load buffer (load requests) and the ROB store-commit path (retiring stores).
- Issues BUS_LOAD/BUS_STORE commands and tracks the one outstanding load by its memory tag.
- Returns load data with its ROB tag to the CDB/writeback stage, and drives the execution stall back to the load buffer.
- Store priority by default, with a starvation guard that eventually favours a waiting load.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_select.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared widths, bus command and arbiter state types
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif

package mem_port_arbiter_pkg;
  localparam int XLEN        = `XLEN;
  localparam int ROB_TAG_LEN = `ROB_TAG_LEN;
  localparam int MEM_TAG_LEN = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_command_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    DROP_WAIT = 2'd2
  } arb_state_t;
endpackage

// File: rtl/mem_port_arbiter_select.sv
// rtl/mem_port_arbiter_select.sv - store-priority selector with load starvation guard
module mem_arb_select #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic ld_req,
  input  logic idle,
  input  logic st_req,
  input  logic accepted,
  output logic ld_sel,
  output logic st_sel
);
  logic [3:0] starve_cnt;
  logic       ld_eligible;
  logic       ld_favoured;

  assign ld_eligible = ld_req && idle;
  assign ld_favoured = starve_cnt >= 4'(STARVE_LIMIT);

  always_comb begin
    ld_sel = 1'b0;
    st_sel = 1'b0;
    if (ld_eligible && st_req) begin
      ld_sel = ld_favoured;
      st_sel = !ld_favoured;
    end else begin
      ld_sel = ld_eligible;
      st_sel = st_req;
    end
  end

  // Held while a load is blocked outside IDLE; only counts losses at the port.
  always_ff @(posedge clock) begin
    if (reset || !ld_req || (ld_sel && accepted)) begin
      starve_cnt <= 4'd0;
    end else if (idle && starve_cnt != 4'd15) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - load/store memory port arbiter; MEM_ARB_PERF_EN adds perf counters
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ld_req,
  input  logic [XLEN-1:0]        ld_addr,
  input  logic [ROB_TAG_LEN-1:0] ld_rob_tag,
  input  logic                   st_req,
  input  logic [XLEN-1:0]        st_addr,
  input  logic [XLEN-1:0]        st_data,
  input  logic                   squash,
  input  logic [3:0]             mem2proc_response,
  input  logic [63:0]            mem2proc_data,
  input  logic [3:0]             mem2proc_tag,
  output bus_command_t           proc2mem_command,
  output logic [XLEN-1:0]        proc2mem_addr,
  output logic [63:0]            proc2mem_data,
  output logic                   lb_exec_stall,
  output logic                   st_grant,
  output logic                   ld_done_valid,
  output logic [XLEN-1:0]        ld_done_data,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]            perf_ld_cnt,
  output logic [31:0]            perf_st_cnt,
  output logic [31:0]            perf_reject_cnt,
`endif
  output logic [ROB_TAG_LEN-1:0] ld_done_rob_tag
);
  arb_state_t             state, next_state;
  logic [MEM_TAG_LEN-1:0] saved_tag;
  logic [ROB_TAG_LEN-1:0] saved_rob_tag;
  logic                   ld_done_q, ld_done_next;
  logic                   ld_sel, st_sel, accepted, tag_hit, ld_accept;
  logic                   unused_data_hi;

  assign unused_data_hi = ^mem2proc_data[63:XLEN];
  assign accepted  = mem2proc_response != 4'd0;
  assign ld_accept = ld_sel && accepted;
  // saved_tag is 0 after reset, so a stale tag never matches.
  assign tag_hit   = (mem2proc_tag != 4'd0) && (mem2proc_tag == saved_tag);

  mem_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
    .clock    (clock),
    .reset    (reset),
    .ld_req   (ld_req),
    .idle     (state == IDLE),
    .st_req   (st_req),
    .accepted (accepted),
    .ld_sel   (ld_sel),
    .st_sel   (st_sel)
  );

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (st_sel) begin
      proc2mem_command = BUS_STORE;
      proc2mem_addr    = st_addr;
      proc2mem_data    = {{(64-XLEN){1'b0}}, st_data};
    end else if (ld_sel) begin
      proc2mem_command = BUS_LOAD;
      proc2mem_addr    = ld_addr;
    end
  end

  assign st_grant      = st_sel && accepted;
  assign lb_exec_stall = ld_req && !ld_accept;
  // A flush in the writeback cycle must still kill the result.
  assign ld_done_valid = ld_done_q && !squash;

  always_comb begin
    next_state   = state;
    ld_done_next = 1'b0;
    case (state)
      IDLE:      if (ld_accept) next_state = LOAD_WAIT;
      LOAD_WAIT: begin
        if (tag_hit) begin
          next_state   = IDLE;
          ld_done_next = !squash;
        end else if (squash) begin
          next_state = DROP_WAIT;
        end
      end
      DROP_WAIT: if (tag_hit) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      saved_tag       <= '0;
      saved_rob_tag   <= '0;
      ld_done_q       <= 1'b0;
      ld_done_data    <= '0;
      ld_done_rob_tag <= '0;
    end else begin
      state     <= next_state;
      ld_done_q <= ld_done_next;
      if (state == IDLE && ld_accept) begin
        saved_tag     <= mem2proc_response;
        saved_rob_tag <= ld_rob_tag;
      end
      if (ld_done_next) begin
        ld_done_data    <= mem2proc_data[XLEN-1:0];
        ld_done_rob_tag <= saved_rob_tag;
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_ld_cnt     <= '0;
      perf_st_cnt     <= '0;
      perf_reject_cnt <= '0;
    end else begin
      if (ld_accept) perf_ld_cnt <= perf_ld_cnt + 32'd1;
      if (st_grant)  perf_st_cnt <= perf_st_cnt + 32'd1;
      if (proc2mem_command != BUS_NONE && !accepted) perf_reject_cnt <= perf_reject_cnt + 32'd1;
    end
  end
`endif
endmodule
